// File: rtl/ksa_engine.sv
// RC4 key-scheduling engine: fills an S-box RAM with S[k]=k, then performs the
// KSA swap loop over it, driving a single-port synchronous RAM from one FSM.
module ksa_engine #(
   parameter int DATA_W    = 8,
   parameter int KEY_BYTES = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   init_only,
   input  logic [8*KEY_BYTES-1:0] key,
   output logic [DATA_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   output logic                   mem_wren,
   input  logic [DATA_W-1:0]      mem_q,
   output logic                   busy,
   output logic                   done,
   output logic [3:0]             dbg_state
);

   localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [KIDX_W-1:0] kidx_t;

   localparam word_t LAST_IDX  = {DATA_W{1'b1}};
   localparam kidx_t LAST_KIDX = kidx_t'(KEY_BYTES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_RD_I, S_WAIT_I, S_RD_J, S_WAIT_J, S_WR_I, S_WR_J, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   word_t                  i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
   kidx_t                  kidx_q, kidx_d;
   logic [8*KEY_BYTES-1:0] key_q, key_d;
   logic                   init_only_q, init_only_d;
   logic [7:0]             kbyte;

   // Handshake: start is taken only in IDLE/DONE; busy covers the whole run and
   // done is a level held in DONE until the next accepted start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         j_q         <= '0;
         si_q        <= '0;
         sj_q        <= '0;
         kidx_q      <= '0;
         key_q       <= '0;
         init_only_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         si_q        <= si_d;
         sj_q        <= sj_d;
         kidx_q      <= kidx_d;
         key_q       <= key_d;
         init_only_q <= init_only_d;
      end
   end

   // Byte 0 of the key sits in the most significant byte.
   always_comb begin
      kbyte = '0;
      for (int k = 0; k < KEY_BYTES; k++) begin
         if (kidx_q == kidx_t'(k)) kbyte = key_q[8*(KEY_BYTES-1-k) +: 8];
      end
   end

   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      si_d        = si_q;
      sj_d        = sj_q;
      kidx_d      = kidx_q;
      key_d       = key_q;
      init_only_d = init_only_q;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_wren    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               key_d       = key;
               init_only_d = init_only;
               i_d         = '0;
               j_d         = '0;
               kidx_d      = '0;
               state_d     = S_INIT;
            end
         end
         S_INIT: begin
            mem_addr  = i_q;
            mem_wdata = i_q;
            mem_wren  = 1'b1;
            i_d       = i_q + word_t'(1);
            if (i_q == LAST_IDX) begin
               i_d     = '0;
               state_d = init_only_q ? S_DONE : S_RD_I;
            end
         end
         S_RD_I: begin
            mem_addr = i_q;
            state_d  = S_WAIT_I;
         end
         S_WAIT_I: begin
            si_d    = mem_q;
            j_d     = j_q + mem_q + word_t'(kbyte);
            state_d = S_RD_J;
         end
         S_RD_J: begin
            mem_addr = j_q;
            state_d  = S_WAIT_J;
         end
         S_WAIT_J: begin
            sj_d    = mem_q;
            state_d = S_WR_I;
         end
         S_WR_I: begin
            mem_addr  = i_q;
            mem_wdata = sj_q;
            mem_wren  = 1'b1;
            state_d   = S_WR_J;
         end
         S_WR_J: begin
            // When i==j both writes carry the same value, so no bypass is needed.
            mem_addr  = j_q;
            mem_wdata = si_q;
            mem_wren  = 1'b1;
            i_d       = i_q + word_t'(1);
            kidx_d    = (kidx_q == LAST_KIDX) ? '0 : kidx_q + kidx_t'(1);
            state_d   = (i_q == LAST_IDX) ? S_DONE : S_RD_I;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done      = (state_q == S_DONE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ksa_engine.sv
// Bench for ksa_engine: an N=256 / 3-byte-key instance and an N=4 / 2-byte-key
// instance, each on its own behavioural RAM, checked against a software RC4 KSA.
module tb_ksa_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int ref_s[256];

  // ---------------- large instance ----------------
  logic        start8, io8;
  logic [23:0] key8;
  logic [7:0]  addr8, wd8, q8, qa8;
  logic        wren8, busy8, done8;
  logic [3:0]  st8;
  logic [7:0]  ram8[256];

  ksa_engine #(.DATA_W(8), .KEY_BYTES(3)) dut8 (
    .clk(clk), .reset(rst_n), .start(start8), .init_only(io8), .key(key8),
    .mem_addr(addr8), .mem_wdata(wd8), .mem_wren(wren8), .mem_q(q8),
    .busy(busy8), .done(done8), .dbg_state(st8)
  );

  always @(posedge clk) begin
    if (wren8) ram8[addr8] <= wd8;
    qa8 <= addr8;
  end
  assign q8 = ram8[qa8];

  // ---------------- small instance ----------------
  logic        start2, io2;
  logic [15:0] key2;
  logic [1:0]  addr2, wd2, q2, qa2;
  logic        wren2, busy2, done2;
  logic [3:0]  st2;
  logic [1:0]  ram2[4];

  ksa_engine #(.DATA_W(2), .KEY_BYTES(2)) dut2 (
    .clk(clk), .reset(rst_n), .start(start2), .init_only(io2), .key(key2),
    .mem_addr(addr2), .mem_wdata(wd2), .mem_wren(wren2), .mem_q(q2),
    .busy(busy2), .done(done2), .dbg_state(st2)
  );

  always @(posedge clk) begin
    if (wren2) ram2[addr2] <= wd2;
    qa2 <= addr2;
  end
  assign q2 = ram2[qa2];

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain RC4 KSA over n entries with a kb-byte key (byte 0 most significant).
  task automatic ksa_ref(input int n, input int kb, input logic [23:0] k, input bit io);
    int j, kbyte, t;
    for (int x = 0; x < 256; x++) ref_s[x] = x;
    if (io) return;
    j = 0;
    for (int x = 0; x < n; x++) begin
      kbyte = int'((k >> (8 * (kb - 1 - (x % kb)))) & 24'hff);
      j = (j + ref_s[x] + kbyte) % n;
      t = ref_s[x]; ref_s[x] = ref_s[j]; ref_s[j] = t;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr8"}, int'(addr8), 0);
    check({tag, "_wdata8"}, int'(wd8), 0);
    check({tag, "_wren8"}, int'(wren8), 0);
    check({tag, "_busy8"}, int'(busy8), 0);
    check({tag, "_done8"}, int'(done8), 0);
  endtask

  task automatic compare_ram8(input string tag);
    logic [7:0] e;
    for (int k = 0; k < 256; k++) exp_q.push_back(ref_s[k][7:0]);
    for (int k = 0; k < 256; k++) begin
      e = exp_q.pop_front();
      check(tag, int'(ram8[k]), int'(e));
    end
  endtask

  // Starts a run and returns cycles from the accepting edge to done (capped).
  task automatic run8(input logic [23:0] k, input bit io, input bit disturb, output int cyc);
    @(negedge clk);
    key8 = k; io8 = io; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    check("busy8_after_start", int'(busy8), 1);
    check("done8_after_start", int'(done8), 0);
    cyc = 0;
    while (cyc < 4000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (disturb && cyc == 300) begin
        key8 = 24'($urandom); io8 = 1'b1; start8 = 1'b1;
      end
      if (disturb && cyc == 301) start8 = 1'b0;
      if (disturb && cyc == 310) key8 = 24'($urandom);
      if (done8) break;
    end
    check("busy8_at_done", int'(busy8), 0);
  endtask

  task automatic run2(input logic [15:0] k, input bit io, output int cyc);
    @(negedge clk);
    key2 = k; io2 = io; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    check("busy2_after_start", int'(busy2), 1);
    check("done2_after_start", int'(done2), 0);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done2) break;
    end
    check("busy2_at_done", int'(busy2), 0);
  endtask

  typedef struct {
    logic [15:0] key;
    bit          init_only;
    logic [7:0]  exp_ram;   // S[0] in bits [7:6]
    int          exp_cyc;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int cyc;
    logic [7:0] packed_ram;
    logic [15:0] rk2;
    logic [23:0] rk8;

    start8 = 0; io8 = 0; key8 = '0;
    start2 = 0; io2 = 0; key2 = '0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset");
    check("reset_wren2", int'(wren2), 0);
    check("reset_busy2", int'(busy2), 0);
    check("reset_done2", int'(done2), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // ---- table-driven runs on the N=4 instance (back-to-back from DONE) ----
    vecs[0] = '{16'h0000, 1'b1, 8'h1B, 4};
    vecs[1] = '{16'h0103, 1'b0, 8'h9C, 28};
    vecs[2] = '{16'h0000, 1'b0, 8'h2D, 28};
    vecs[3] = '{16'h0103, 1'b1, 8'h1B, 4};
    vecs[4] = '{16'h0103, 1'b0, 8'h9C, 28};
    for (int v = 0; v < 5; v++) begin
      run2(vecs[v].key, vecs[v].init_only, cyc);
      check($sformatf("vec%0d_cycles", v), cyc, vecs[v].exp_cyc);
      packed_ram = vecs[v].exp_ram;
      for (int k = 0; k < 4; k++)
        check($sformatf("vec%0d_ram[%0d]", v, k), int'(ram2[k]), int'(packed_ram[6-2*k +: 2]));
      repeat (2) @(posedge clk);
      #1 check($sformatf("vec%0d_wren_idle", v), int'(wren2), 0);
      check($sformatf("vec%0d_done_held", v), int'(done2), 1);
    end

    // ---- random keys on the N=4 instance ----
    for (int r = 0; r < 8; r++) begin
      rk2 = 16'($urandom_range(0, 65535));
      run2(rk2, 1'b0, cyc);
      check("rand2_cycles", cyc, 28);
      ksa_ref(4, 2, {8'h00, rk2}, 1'b0);
      for (int k = 0; k < 4; k++)
        check($sformatf("rand2_ram[%0d]", k), int'(ram2[k]), ref_s[k]);
    end

    // ---- N=256: init-only, then full run with disturbance, then back-to-back ----
    run8(24'hABCDEF, 1'b1, 1'b0, cyc);
    check("init8_cycles", cyc, 256);
    ksa_ref(256, 3, 24'h0, 1'b1);
    compare_ram8("init8_ram");

    run8(24'h000249, 1'b0, 1'b1, cyc);
    check("full8_cycles", cyc, 1792);
    ksa_ref(256, 3, 24'h000249, 1'b0);
    compare_ram8("full8_ram");

    rk8 = 24'($urandom);
    run8(rk8, 1'b0, 1'b0, cyc);
    check("b2b8_cycles", cyc, 1792);
    ksa_ref(256, 3, rk8, 1'b0);
    compare_ram8("b2b8_ram");

    // ---- asynchronous reset in the middle of the swap phase ----
    @(negedge clk);
    key8 = 24'h123456; io8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (500) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check_outputs_zero("postreset");

    rk8 = 24'($urandom);
    run8(rk8, 1'b0, 1'b0, cyc);
    check("after_reset_cycles", cyc, 1792);
    ksa_ref(256, 3, rk8, 1'b0);
    compare_ram8("after_reset_ram");
    @(posedge clk);
    #1 check("after_reset_wren_idle", int'(wren8), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
